// File: rtl/fde_pkg.sv
// rtl/fde_pkg.sv - shared constants and state encoding for the fetch/decode sequencer
package fde_pkg;

  localparam int OPC_W     = 4;
  localparam int NUM_UNITS = 4;
  localparam int TMO_W     = 4;
  localparam int TMO_CYC   = 15;

  localparam logic [3:0] HALT_OPC = 4'hF;

  // Opcode k starts execution unit k.
  localparam int UNIT_REGALU = 0;
  localparam int UNIT_LDST   = 1;
  localparam int UNIT_BRANCH = 2;
  localparam int UNIT_IMM    = 3;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ADDR   = 4'd1,
    ST_READ   = 4'd2,
    ST_LATCH  = 4'd3,
    ST_DECODE = 4'd4,
    ST_ISSUE  = 4'd5,
    ST_WAIT   = 4'd6,
    ST_HALTED = 4'd7,
    ST_FAULT  = 4'd8
  } state_t;

endpackage

// File: rtl/cycle_watchdog.sv
// rtl/cycle_watchdog.sv - loadable down-counter bounding memory and execution waits
// zero_o is high when one more decrement leaves the count at zero (or it already is).
module cycle_watchdog #(
  parameter int TMO_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [TMO_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q <= TMO_W'(1));

endmodule

// File: rtl/fetch_decode_seq.sv
// rtl/fetch_decode_seq.sv - fetches one instruction, decodes it and hands it to one execution unit
// Outputs are registered from the next state, so they always reflect the current state only.
module fetch_decode_seq #(
  parameter int               OPC_W     = fde_pkg::OPC_W,
  parameter int               NUM_UNITS = fde_pkg::NUM_UNITS,
  parameter logic [OPC_W-1:0] HALT_OPC  = OPC_W'(fde_pkg::HALT_OPC),
  parameter int               TMO_CYC   = fde_pkg::TMO_CYC,
  parameter int               TMO_W     = fde_pkg::TMO_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  output logic                 PC_out,
  output logic                 MAR_in,
  output logic                 Mem_rd,
  input  logic                 mem_ack,
  output logic                 IR_in,
  input  logic [OPC_W-1:0]     ir_opcode,
  output logic [NUM_UNITS-1:0] unit_start,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic                 busy,
  output logic                 Halt,
  output logic                 Fault
);

  import fde_pkg::*;

  localparam int SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             wd_load, wd_dec, wd_zero;
  logic             sel_done;

  // Only the unit that was started may end the instruction.
  assign sel_done = unit_done[sel_q];

  cycle_watchdog #(
    .TMO_W (TMO_W)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .load_i     (wd_load),
    .load_val_i (TMO_W'(TMO_CYC)),
    .dec_i      (wd_dec),
    .zero_o     (wd_zero)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wd_load = 1'b0;
    wd_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        wd_load = 1'b1;
        state_d = ST_READ;
      end
      ST_READ: begin
        if (mem_ack) begin
          state_d = ST_LATCH;
        end else begin
          wd_dec = 1'b1;
          if (wd_zero) state_d = ST_FAULT;
        end
      end
      ST_LATCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (int'(ir_opcode) < NUM_UNITS) begin
          sel_d   = SEL_W'(ir_opcode);
          state_d = ST_ISSUE;
        end else if (ir_opcode == HALT_OPC) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_ISSUE: begin
        // unit_done is not looked at here: a unit cannot finish in zero cycles.
        wd_load = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sel_done) begin
          state_d = run ? ST_ADDR : ST_IDLE;
        end else begin
          wd_dec = 1'b1;
          if (wd_zero) state_d = ST_FAULT;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      PC_out     <= 1'b0;
      MAR_in     <= 1'b0;
      Mem_rd     <= 1'b0;
      IR_in      <= 1'b0;
      unit_start <= '0;
      busy       <= 1'b0;
      Halt       <= 1'b0;
      Fault      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      PC_out     <= (state_d == ST_ADDR);
      MAR_in     <= (state_d == ST_ADDR);
      Mem_rd     <= (state_d == ST_READ);
      IR_in      <= (state_d == ST_LATCH);
      unit_start <= (state_d == ST_ISSUE) ? (NUM_UNITS'(1) << sel_d) : '0;
      busy       <= !(state_d inside {ST_IDLE, ST_HALTED, ST_FAULT});
      Halt       <= (state_d == ST_HALTED);
      Fault      <= (state_d == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_fetch_decode_seq.sv
// tb/tb_fetch_decode_seq.sv - directed vector bench for the fetch/decode sequencer
module tb_fetch_decode_seq;

  logic       clk;
  logic       reset;
  logic       run;
  logic       PC_out, MAR_in, Mem_rd, IR_in;
  logic       mem_ack;
  logic [3:0] ir_opcode;
  logic [3:0] unit_start;
  logic [3:0] unit_done;
  logic       busy, Halt, Fault;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected output vector: {PC_out, MAR_in, Mem_rd, IR_in, unit_start[3:0], busy, Halt, Fault}
  localparam logic [10:0] O_IDLE  = 11'b0000_0000_000;
  localparam logic [10:0] O_ADDR  = 11'b1100_0000_100;
  localparam logic [10:0] O_READ  = 11'b0010_0000_100;
  localparam logic [10:0] O_LATCH = 11'b0001_0000_100;
  localparam logic [10:0] O_DEC   = 11'b0000_0000_100;
  localparam logic [10:0] O_WAIT  = 11'b0000_0000_100;
  localparam logic [10:0] O_ISS0  = 11'b0000_0001_100;
  localparam logic [10:0] O_ISS1  = 11'b0000_0010_100;
  localparam logic [10:0] O_ISS2  = 11'b0000_0100_100;
  localparam logic [10:0] O_ISS3  = 11'b0000_1000_100;
  localparam logic [10:0] O_HALT  = 11'b0000_0000_010;
  localparam logic [10:0] O_FAULT = 11'b0000_0000_001;

  typedef struct {
    logic        run;
    logic        ack;
    logic [3:0]  opc;
    logic [3:0]  done;
    logic [10:0] exp;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  fetch_decode_seq dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .PC_out     (PC_out),
    .MAR_in     (MAR_in),
    .Mem_rd     (Mem_rd),
    .mem_ack    (mem_ack),
    .IR_in      (IR_in),
    .ir_opcode  (ir_opcode),
    .unit_start (unit_start),
    .unit_done  (unit_done),
    .busy       (busy),
    .Halt       (Halt),
    .Fault      (Fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] act;
    act = {PC_out, MAR_in, Mem_rd, IR_in, unit_start, busy, Halt, Fault};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    run       = 1'b0;
    mem_ack   = 1'b0;
    unit_done = 4'b0;
    tick();
    reset = 1'b0;
  endtask

  // From IDLE: fetch with an immediate ack and stop in DECODE with opc on the IR.
  task automatic to_decode(input logic [3:0] opc);
    run = 1'b1;
    tick();
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack   = 1'b0;
    ir_opcode = opc;
    tick();
    check("at_decode", O_DEC);
  endtask

  initial begin
    // Two back-to-back instructions: RegALU with immediate ack, then IMM with a delayed ack.
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 4'b0000, O_IDLE};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 4'b0000, O_ADDR};
    vecs[2]  = '{1'b1, 1'b1, 4'h0, 4'b0000, O_READ};
    vecs[3]  = '{1'b1, 1'b0, 4'h0, 4'b0000, O_LATCH};
    vecs[4]  = '{1'b1, 1'b0, 4'h0, 4'b0000, O_DEC};
    vecs[5]  = '{1'b1, 1'b0, 4'h0, 4'b0001, O_ISS0};
    vecs[6]  = '{1'b1, 1'b0, 4'h0, 4'b0000, O_WAIT};
    vecs[7]  = '{1'b1, 1'b0, 4'h0, 4'b0000, O_WAIT};
    vecs[8]  = '{1'b1, 1'b0, 4'h0, 4'b0000, O_WAIT};
    vecs[9]  = '{1'b1, 1'b0, 4'h0, 4'b0001, O_WAIT};
    vecs[10] = '{1'b1, 1'b0, 4'h3, 4'b0000, O_ADDR};
    vecs[11] = '{1'b1, 1'b0, 4'h3, 4'b0000, O_READ};
    vecs[12] = '{1'b1, 1'b0, 4'h3, 4'b0000, O_READ};
    vecs[13] = '{1'b1, 1'b0, 4'h3, 4'b0000, O_READ};
    vecs[14] = '{1'b1, 1'b1, 4'h3, 4'b0000, O_READ};
    vecs[15] = '{1'b1, 1'b0, 4'h3, 4'b0000, O_LATCH};
    vecs[16] = '{1'b1, 1'b0, 4'h3, 4'b0000, O_DEC};
    vecs[17] = '{1'b1, 1'b0, 4'h3, 4'b0000, O_ISS3};
    vecs[18] = '{1'b0, 1'b0, 4'h3, 4'b0001, O_WAIT};
    vecs[19] = '{1'b0, 1'b0, 4'h3, 4'b1000, O_WAIT};
    vecs[20] = '{1'b0, 1'b0, 4'h3, 4'b0000, O_IDLE};
    vecs[21] = '{1'b0, 1'b0, 4'h3, 4'b0000, O_IDLE};

    ir_opcode = 4'h0;
    do_reset();
    check("reset_state", O_IDLE);

    for (int i = 0; i < NVEC; i++) begin
      run       = vecs[i].run;
      mem_ack   = vecs[i].ack;
      ir_opcode = vecs[i].opc;
      unit_done = vecs[i].done;
      check($sformatf("vec%0d", i), vecs[i].exp);
      tick();
    end
    unit_done = 4'b0;
    mem_ack   = 1'b0;

    // Ack arriving on the last READ cycle the watchdog allows still wins.
    do_reset();
    run = 1'b1;
    tick();
    tick();
    for (int k = 1; k < 15; k++) begin
      check("read_hold", O_READ);
      tick();
    end
    mem_ack = 1'b1;
    check("read_last_cycle", O_READ);
    tick();
    mem_ack = 1'b0;
    check("ack_at_expiry", O_LATCH);

    // No ack at all: fault after 15 READ cycles.
    do_reset();
    run = 1'b1;
    tick();
    tick();
    for (int k = 1; k < 15; k++) tick();
    check("read_c15", O_READ);
    tick();
    check("read_timeout", O_FAULT);

    // Illegal opcode faults, holds with run high, clears only on reset.
    do_reset();
    to_decode(4'h7);
    tick();
    check("illegal_fault", O_FAULT);
    for (int k = 0; k < 5; k++) tick();
    check("fault_sticky", O_FAULT);
    do_reset();
    check("fault_cleared", O_IDLE);

    // Halt opcode parks the sequencer.
    to_decode(4'hF);
    tick();
    check("halted", O_HALT);
    for (int k = 0; k < 20; k++) begin
      tick();
      check("halt_sticky", O_HALT);
    end

    // Execution timeout with stray done pulses from an unselected unit.
    do_reset();
    to_decode(4'(fde_pkg::UNIT_BRANCH));
    unit_done = 4'b0100;
    tick();
    check("issue_branch", O_ISS2);
    unit_done = 4'b0000;
    tick();
    for (int k = 1; k < 15; k++) begin
      unit_done = (k % 3 == 0) ? 4'b0010 : 4'b0000;
      check("wait_hold", O_WAIT);
      tick();
    end
    unit_done = 4'b0010;
    check("wait_c15", O_WAIT);
    tick();
    unit_done = 4'b0000;
    check("wait_timeout", O_FAULT);

    // Reset in WAIT right after a start, then a clean restart.
    do_reset();
    to_decode(4'(fde_pkg::UNIT_LDST));
    tick();
    check("issue_ldst", O_ISS1);
    tick();
    check("wait_ldst", O_WAIT);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_in_wait", O_IDLE);
    run = 1'b1;
    tick();
    check("restart_addr", O_ADDR);
    tick();
    check("restart_read", O_READ);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    check("restart_issue", O_ISS1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
